// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM encodings,
// default operand width and the iteration-counter width helper.
package shift_add_multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // Counter must hold the value WIDTH itself, hence WIDTH+1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_add_multiplier_adder.sv
// 4-bit ripple-carry adder used as the multiplier's accumulate datapath.
module shift_add_multiplier_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fa
            assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[4];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier: one conditional add plus right shift of
// {C,A,Q} per clock, WIDTH iterations, product reported with a done pulse.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = cnt_width(WIDTH);

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   a_reg, a_next;
    logic [WIDTH-1:0]   q_reg, q_next;
    logic [WIDTH-1:0]   m_reg, m_next;
    logic               c_reg, c_next;
    logic [CW-1:0]      count_reg, count_next;
    logic [2*WIDTH-1:0] product_reg, product_next;

    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic [WIDTH-1:0]   acc_a;
    logic               acc_c;
    logic [2*WIDTH:0]   shifted;

    generate
        if (WIDTH == 4) begin : g_rca
            shift_add_multiplier_adder u_adder (
                .a    (a_reg),
                .b    (m_reg),
                .cin  (1'b0),
                .sum  (add_sum),
                .cout (add_cout)
            );
        end else begin : g_beh
            assign {add_cout, add_sum} = {1'b0, a_reg} + {1'b0, m_reg};
        end
    endgenerate

    // Add and shift both come from the pre-edge registers; carry lands in
    // the top of A after the shift, so nothing is lost.
    assign acc_a   = q_reg[0] ? add_sum  : a_reg;
    assign acc_c   = q_reg[0] ? add_cout : 1'b0;
    assign shifted = {1'b0, acc_c, acc_a, q_reg[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            a_reg       <= '0;
            q_reg       <= '0;
            m_reg       <= '0;
            c_reg       <= 1'b0;
            count_reg   <= '0;
            product_reg <= '0;
        end else begin
            state_reg   <= state_next;
            a_reg       <= a_next;
            q_reg       <= q_next;
            m_reg       <= m_next;
            c_reg       <= c_next;
            count_reg   <= count_next;
            product_reg <= product_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        a_next       = a_reg;
        q_next       = q_reg;
        m_next       = m_reg;
        c_next       = c_reg;
        count_next   = count_reg;
        product_next = product_reg;

        unique case (state_reg)
            IDLE, DONE: begin
                state_next = IDLE;
                if (start) begin
                    m_next     = multiplicand;
                    q_next     = multiplier;
                    a_next     = '0;
                    c_next     = 1'b0;
                    count_next = CW'(WIDTH);
                    state_next = RUN;
                end
            end
            RUN: begin
                a_next     = shifted[2*WIDTH-1:WIDTH];
                q_next     = shifted[WIDTH-1:0];
                c_next     = shifted[2*WIDTH];
                count_next = count_reg - CW'(1);
                if (count_reg == CW'(1)) begin
                    product_next = shifted[2*WIDTH-1:0];
                    state_next   = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy    = (state_reg == RUN);
    assign done    = (state_reg == DONE);
    assign product = product_reg;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier: scoreboard of expected products
// popped on each done pulse, plus cycle-exact busy/done timing checks.
module tb_shift_add_multiplier;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] multiplicand;
    logic [3:0] multiplier;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int n_cmp = 0;
    int n_err = 0;
    int dones_seen = 0;
    logic [7:0] exp_q[$];

    shift_add_multiplier #(.WIDTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard side: every done pulse consumes one expected product.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            dones_seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(product), 32'hDEAD);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                chk("product", 32'(product), 32'(e));
                $display("done: product=%02h expected=%02h", product, e);
            end
        end
    end

    task automatic issue(input logic [3:0] m, input logic [3:0] q);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        exp_q.push_back(8'(m) * 8'(q));
        $display("start: %0d x %0d", m, q);
    endtask

    // Called at the negedge where start is driven; ends at the done negedge.
    task automatic run_timed(input string tag);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_nodone"}, 32'(done), 32'd0);
            @(negedge clk);
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst = 1'b1;
        start = 1'b0;
        multiplicand = '0;
        multiplier = '0;

        // Reset with start also high: reset must win.
        @(negedge clk);
        start = 1'b1;
        multiplicand = 4'd7;
        multiplier = 4'd7;
        @(negedge clk);
        start = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_product", 32'(product), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(4'd3, 4'd5);
        run_timed("op3x5");
        @(negedge clk);

        issue(4'd15, 4'd15);
        run_timed("op15x15");
        @(negedge clk);

        issue(4'd0, 4'd9);
        run_timed("op0x9");
        repeat (3) @(negedge clk);
        chk("hold_zero", 32'(product), 32'h00);
        issue(4'd1, 4'd1);
        @(negedge clk);
        start = 1'b0;
        chk("hold_during_run", 32'(product), 32'h00);
        repeat (3) @(negedge clk);
        @(negedge clk);
        chk("op1x1_done", 32'(done), 32'd1);
        @(negedge clk);

        // Re-pulse start mid-run with different operands: must be ignored.
        issue(4'd10, 4'd6);
        d0 = dones_seen;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        multiplicand = 4'd2;
        multiplier = 4'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("ignore_done", 32'(done), 32'd1);
        repeat (6) @(negedge clk);
        chk("ignore_nobusy", 32'(busy), 32'd0);
        chk("ignore_single_done", 32'(dones_seen - d0), 32'd1);

        // Back-to-back: start 9x9 in the DONE cycle of 7x3.
        issue(4'd7, 4'd3);
        run_timed("op7x3");
        issue(4'd9, 4'd9);
        run_timed("op9x9");
        @(negedge clk);

        // Reset after two RUN edges: no done, product cleared.
        multiplicand = 4'd13;
        multiplier = 4'd11;
        start = 1'b1;
        $display("start: 13 x 11 (to be aborted)");
        d0 = dones_seen;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_product", 32'(product), 32'h00);
        repeat (6) @(negedge clk);
        chk("abort_no_done", 32'(dones_seen - d0), 32'd0);

        issue(4'd13, 4'd11);
        run_timed("op13x11");
        repeat (2) @(negedge clk);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("total_dones", 32'(dones_seen), 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
